// File: rtl/vram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : vram_ctrl
// Desc    : Dual-port framebuffer with queued CPU pixel writes, clear-screen
//           engine and 4x4-replicated registered display read port.
//           Optional macro VRAM_VBLANK_WR_EN restricts write-port cycles to
//           rdn=1 (blanking).
// Rev     : 1.0  initial release
// ============================================================================
module vram_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int FB_W       = 160,
  parameter int FB_H       = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_x,
  input  logic [6:0]  wr_y,
  input  logic [11:0] wr_data,
  input  logic        clr_req,
  input  logic [11:0] clr_color,
  output logic        busy,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        rdn,
  output logic [11:0] d_out
);

  localparam int c_NPIX = FB_W * FB_H;
  localparam int c_AW   = $clog2(c_NPIX);
  localparam int c_PW   = $clog2(FIFO_DEPTH);
  localparam logic [c_PW:0]   c_FULL = (c_PW + 1)'(FIFO_DEPTH);
  localparam logic [c_AW-1:0] c_LAST = c_AW'(c_NPIX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [11:0]       mem [0:c_NPIX-1];
  logic [7:0]        r_fx   [0:FIFO_DEPTH-1];
  logic [6:0]        r_fy   [0:FIFO_DEPTH-1];
  logic [11:0]       r_fd   [0:FIFO_DEPTH-1];
  logic [c_PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_PW:0]     r_count;
  logic              r_clr_pend;
  logic [11:0]       r_clr_color;
  logic [c_AW-1:0]   r_clr_addr;
  logic              w_en, w_push, w_pop, w_clr_go, w_we;
  logic [c_AW-1:0]   w_waddr, w_rd_addr;
  logic [11:0]       w_wdata;
  logic              w_unused;

`ifdef VRAM_VBLANK_WR_EN
  assign w_en = rdn;
`else
  assign w_en = 1'b1;
`endif

  assign wr_ready  = (r_count < c_FULL) && !r_clr_pend && (r_state == IDLE);
  assign busy      = (r_state != IDLE) || (r_count != '0) || r_clr_pend;
  assign w_push    = wr_valid && wr_ready;
  assign w_rd_addr = c_AW'(32'(row_addr[8:2]) * FB_W + 32'(col_addr[9:2]));
  assign w_unused  = &{1'b0, row_addr[1:0], col_addr[1:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_clr_go    = 1'b0;
    w_we        = 1'b0;
    w_waddr     = '0;
    w_wdata     = '0;
    case (r_state)
      IDLE: begin
        // Pending writes always win over a pending clear.
        if (w_en) begin
          if (r_count != '0) begin
            w_state_nxt = DRAIN;
          end else if (r_clr_pend) begin
            w_state_nxt = CLEAR;
            w_clr_go    = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (w_en) begin
          if (r_count == '0) begin
            w_state_nxt = IDLE;
          end else begin
            w_pop   = 1'b1;
            w_waddr = c_AW'(32'(r_fy[r_rd_ptr]) * FB_W + 32'(r_fx[r_rd_ptr]));
            w_wdata = r_fd[r_rd_ptr];
            w_we    = (32'(r_fx[r_rd_ptr]) < FB_W) && (32'(r_fy[r_rd_ptr]) < FB_H);
            if (r_count == (c_PW + 1)'(1)) w_state_nxt = IDLE;
          end
        end
      end
      CLEAR: begin
        if (w_en) begin
          w_we    = 1'b1;
          w_waddr = r_clr_addr;
          w_wdata = r_clr_color;
          if (r_clr_addr == c_LAST) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_clr_pend  <= 1'b0;
      r_clr_color <= '0;
      r_clr_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_clr_go) begin
        r_clr_pend <= 1'b0;
      end else if (clr_req && !r_clr_pend && r_state != CLEAR) begin
        r_clr_pend  <= 1'b1;
        r_clr_color <= clr_color;
      end
      if (r_state == CLEAR && w_en)
        r_clr_addr <= (r_clr_addr == c_LAST) ? '0 : r_clr_addr + 1'b1;
    end
  end

  // Queue payload and RAM are not reset; only control state is.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fx[r_wr_ptr] <= wr_x;
      r_fy[r_wr_ptr] <= wr_y;
      r_fd[r_wr_ptr] <= wr_data;
    end
    if (w_we) mem[w_waddr] <= w_wdata;
  end

  // Read sees pre-write contents on a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       d_out <= 12'h000;
    else if (!rdn) d_out <= mem[w_rd_addr];
    else           d_out <= 12'h000;
  end

endmodule
`default_nettype wire
